// File: rtl/axis_s2mm_framer.sv
// Purpose : AXI4-Stream framing stage in front of the DMA S2MM port. Counts beats,
//           tags TLAST every cfg_pkt_len beats (or on upstream TLAST / flush) and
//           registers the stream through a 2-entry skid buffer.
// Latency : 1 cycle from input handshake to m_axis_tvalid when the buffer is empty;
//           1 beat/cycle sustained while m_axis_tready=1.
// Backpressure: s_axis_tready is a registered "skid not full" flag, never a
//           combinational function of m_axis_tready; it is also gated by cfg_en
//           between packets.
//
// Ports:
//   sys_clk, perif_rst          single clock, synchronous active-high reset
//   cfg_pkt_len, cfg_en, flush  framing control (length 0 behaves as 1)
//   s_axis_*                    upstream stream from the role
//   m_axis_*                    framed stream to the DMA
//   pkt_cnt, busy               status for the user register file
module axis_s2mm_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    sys_clk,
    input  logic                    perif_rst,
    input  logic [LEN_WIDTH-1:0]    cfg_pkt_len,
    input  logic                    cfg_en,
    input  logic                    flush,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [CNT_WIDTH-1:0]    pkt_cnt,
    output logic                    busy
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
    } beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_t;

    // Framing state
    state_t               state;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [LEN_WIDTH-1:0] len_lat;
    logic                 flush_pend;

    // Skid buffer state
    beat_t main_q;
    beat_t skid_q;
    logic  main_vld;
    logic  skid_vld;
    logic  not_full;

    logic                 in_fire;
    logic                 out_fire;
    logic                 tag;
    logic                 skid_vld_nxt;
    logic [LEN_WIDTH-1:0] cfg_len_eff;
    logic [LEN_WIDTH-1:0] len_cur;
    beat_t                in_beat;

    assign cfg_len_eff = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;

    // The first beat of a packet is judged against the live config, later
    // beats against the length latched when the packet opened.
    assign len_cur = (state == OPEN) ? len_lat : cfg_len_eff;

    // Between packets cfg_en holds the stream off; an open packet always completes.
    assign s_axis_tready = not_full & ((state == OPEN) | cfg_en);

    assign in_fire  = s_axis_tvalid & s_axis_tready;
    assign out_fire = main_vld & m_axis_tready;

    // A flush while idle is dropped so that no empty packet can ever be produced.
    assign tag = (beat_cnt == len_cur - LEN_WIDTH'(1))
               | s_axis_tlast
               | flush_pend
               | (flush & (state == OPEN));

    assign in_beat = beat_t'{dat: s_axis_tdata, keep: s_axis_tkeep, last: tag};

    // Skid only holds data while the main register is stalled.
    assign skid_vld_nxt = (main_vld & ~m_axis_tready) & (skid_vld | in_fire);

    always_ff @(posedge sys_clk) begin
        if (perif_rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            len_lat    <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (in_fire) begin
                if (tag) begin
                    state      <= IDLE;
                    beat_cnt   <= '0;
                    flush_pend <= 1'b0;
                end else begin
                    state    <= OPEN;
                    beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                    if (state == IDLE) begin
                        len_lat <= cfg_len_eff;
                    end
                end
            end else if (flush && (state == OPEN)) begin
                flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (perif_rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            not_full <= 1'b0;
        end else begin
            if (!main_vld || m_axis_tready) begin
                // Main register is free this cycle: the older skid beat goes first.
                if (skid_vld) begin
                    main_q   <= skid_q;
                    main_vld <= 1'b1;
                    skid_vld <= 1'b0;
                end else begin
                    main_vld <= in_fire;
                    if (in_fire) begin
                        main_q <= in_beat;
                    end
                end
            end else if (in_fire) begin
                skid_q   <= in_beat;
                skid_vld <= 1'b1;
            end
            not_full <= ~skid_vld_nxt;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (perif_rst) begin
            pkt_cnt <= '0;
        end else if (out_fire && main_q.last) begin
            pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
        end
    end

    assign m_axis_tdata  = main_q.dat;
    assign m_axis_tkeep  = main_q.keep;
    assign m_axis_tlast  = main_q.last;
    assign m_axis_tvalid = main_vld;

    assign busy = (state == OPEN) | main_vld | skid_vld;

endmodule

// File: tb/tb_axis_s2mm_framer.sv
// Purpose : directed bench for axis_s2mm_framer (framing, flush, cfg_en, skid, reset).
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Output beats are collected by a monitor and compared against hand-listed expectations.
module tb_axis_s2mm_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_len = 16'd4;
    logic        cfg_en = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] s_data = '0;
    logic [3:0]  s_keep = '0;
    logic        s_vld = 1'b0;
    logic        s_last = 1'b0;
    logic        s_rdy;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_vld;
    logic        m_last;
    logic        m_rdy = 1'b1;
    logic [31:0] pkt_cnt;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    axis_s2mm_framer #(
        .DATA_WIDTH(32),
        .LEN_WIDTH (16),
        .CNT_WIDTH (32)
    ) dut (
        .sys_clk      (clk),
        .perif_rst    (rst),
        .cfg_pkt_len  (cfg_len),
        .cfg_en       (cfg_en),
        .flush        (flush),
        .s_axis_tdata (s_data),
        .s_axis_tkeep (s_keep),
        .s_axis_tvalid(s_vld),
        .s_axis_tlast (s_last),
        .s_axis_tready(s_rdy),
        .m_axis_tdata (m_data),
        .m_axis_tkeep (m_keep),
        .m_axis_tvalid(m_vld),
        .m_axis_tlast (m_last),
        .m_axis_tready(m_rdy),
        .pkt_cnt      (pkt_cnt),
        .busy         (busy)
    );

    // Output beats that will transfer on the coming rising edge.
    always @(negedge clk) begin
        if (m_vld && m_rdy) got_q.push_back({m_keep, m_last, m_data});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge so
    // consecutive calls stream back-to-back.
    task automatic send(input logic [31:0] d, input logic ul, input logic el);
        int n = 0;
        s_vld  = 1'b1;
        s_data = d;
        s_keep = d[3:0];
        s_last = ul;
        @(negedge clk);
        while (!s_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", {63'd0, s_rdy}, 64'd1);
        exp_q.push_back({d[3:0], el, d});
        @(posedge clk);
        #1;
        s_vld  = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check(tag, 64'(got_q[i]), 64'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_vld",  {63'd0, m_vld},  64'd0);
        check("rst_s_rdy",  {63'd0, s_rdy},  64'd0);
        check("rst_pkt",    64'(pkt_cnt),    64'd0);
        check("rst_busy",   {63'd0, busy},   64'd0);
        check("rst_data",   64'(m_data),     64'd0);
        check("rst_keep",   64'(m_keep),     64'd0);
        check("rst_last",   {63'd0, m_last}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1);
        @(negedge clk);
        check("post_rst_rdy", {63'd0, s_rdy}, 64'd1);
        @(posedge clk);
        #1;

        // ---------------- T1: len=4, 12 beats back-to-back ----------------
        for (int i = 0; i < 12; i++) begin
            s_vld  = 1'b1;
            s_data = 32'h100 + i;
            s_keep = 4'hF;
            s_last = 1'b0;
            @(negedge clk);
            check("t1_tready", {63'd0, s_rdy}, 64'd1);
            if (i > 0) begin
                check("t1_vld",  {63'd0, m_vld},  64'd1);
                check("t1_data", 64'(m_data),     64'(32'h100 + i - 1));
                check("t1_last", {63'd0, m_last}, {63'd0, ((i - 1) % 4) == 3});
            end
            @(posedge clk);
            #1;
        end
        s_vld = 1'b0;
        @(negedge clk);
        check("t1_data11", 64'(m_data),     64'h10b);
        check("t1_last11", {63'd0, m_last}, 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_pkt",  64'(pkt_cnt),   64'd3);
        check("t1_vld0", {63'd0, m_vld}, 64'd0);
        check("t1_busy", {63'd0, busy},  64'd0);
        got_q.delete();
        @(posedge clk);
        #1;

        // ---------------- T2: len=4, tready toggling, random valid ----------------
        k = 0;
        n = 0;
        while (k < 16 && n < 400) begin
            m_rdy  = ~m_rdy;
            s_vld  = ($urandom_range(0, 3) != 0);
            s_data = 32'h200 + k;
            s_keep = 4'(k);
            s_last = 1'b0;
            @(negedge clk);
            if (s_vld && s_rdy) begin
                exp_q.push_back({4'(k), ((k % 4) == 3), 32'h200 + k});
                k++;
            end
            n++;
            @(posedge clk);
            #1;
        end
        check("t2_all_sent", 64'(k), 64'd16);
        s_vld = 1'b0;
        m_rdy = 1'b1;
        cyc(4);
        compare_q("t2_stream");
        @(negedge clk);
        check("t2_pkt", 64'(pkt_cnt), 64'd7);
        @(posedge clk);
        #1;

        // ---------------- T3: len=8, flush mid-packet and while idle ----------------
        cfg_len = 16'd8;
        send(32'h300, 1'b0, 1'b0);
        send(32'h301, 1'b0, 1'b0);
        send(32'h302, 1'b0, 1'b0);
        pulse_flush();
        send(32'h303, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) send(32'h310 + i, 1'b0, i == 7);
        cyc(3);
        pulse_flush();
        cyc(3);
        @(negedge clk);
        check("t3_pkt_idle_flush", 64'(pkt_cnt),  64'd9);
        check("t3_busy_idle",      {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send(32'h320 + i, 1'b0, i == 7);
        cyc(3);
        compare_q("t3_stream");
        @(negedge clk);
        check("t3_pkt", 64'(pkt_cnt), 64'd10);
        @(posedge clk);
        #1;

        // ---------------- T4: len=0 and upstream tlast ----------------
        cfg_len = 16'd0;
        send(32'h400, 1'b0, 1'b1);
        send(32'h401, 1'b0, 1'b1);
        send(32'h402, 1'b0, 1'b1);
        cfg_len = 16'd4;
        send(32'h410, 1'b0, 1'b0);
        send(32'h411, 1'b1, 1'b1);
        send(32'h420, 1'b0, 1'b0);
        send(32'h421, 1'b0, 1'b0);
        send(32'h422, 1'b0, 1'b0);
        send(32'h423, 1'b0, 1'b1);
        cyc(3);
        compare_q("t4_stream");
        @(negedge clk);
        check("t4_pkt", 64'(pkt_cnt), 64'd15);
        @(posedge clk);
        #1;

        // ---------------- T5: cfg_en dropped mid-packet ----------------
        send(32'h500, 1'b0, 1'b0);
        send(32'h501, 1'b0, 1'b0);
        cfg_en = 1'b0;
        send(32'h502, 1'b0, 1'b0);
        send(32'h503, 1'b0, 1'b1);
        s_vld  = 1'b1;
        s_data = 32'h5ff;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_stall", {63'd0, s_rdy}, 64'd0);
            @(posedge clk);
            #1;
        end
        s_vld  = 1'b0;
        cfg_en = 1'b1;
        @(negedge clk);
        check("t5_reenable", {63'd0, s_rdy}, 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(32'h510 + i, 1'b0, i == 3);
        cyc(3);
        compare_q("t5_stream");
        @(negedge clk);
        check("t5_pkt", 64'(pkt_cnt), 64'd17);
        @(posedge clk);
        #1;

        // ---------------- T6: reset with skid full ----------------
        m_rdy  = 1'b0;
        s_vld  = 1'b1;
        s_data = 32'h600;
        s_keep = 4'hF;
        @(posedge clk);
        #1;
        s_data = 32'h601;
        @(posedge clk);
        #1;
        s_vld = 1'b0;
        @(negedge clk);
        check("t6_skid_full_rdy", {63'd0, s_rdy}, 64'd0);
        check("t6_busy",          {63'd0, busy},  64'd1);
        check("t6_head",          64'(m_data),    64'h600);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_rdy = 1'b1;
        @(negedge clk);
        check("t6_rst_vld",  {63'd0, m_vld}, 64'd0);
        check("t6_rst_pkt",  64'(pkt_cnt),   64'd0);
        check("t6_rst_busy", {63'd0, busy},  64'd0);
        got_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(32'h610 + i, 1'b0, i == 3);
        cyc(3);
        compare_q("t6_stream");
        @(negedge clk);
        check("t6_pkt", 64'(pkt_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
